// File: rtl/bit1_counter.sv
// Serial 1-bit counter: captures an 8-bit word, counts its set bits one per clock,
// and publishes the count (saturated to 7) on a fixed 10-clock cycle.
module bit1_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    output logic [2:0] bit_cnt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ACC_W  = 4;

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  acc_sat_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and saturated accumulator view
    always_comb begin
        state_nxt = ST_CAPTURE;
        acc_sat_c = acc_q[ACC_W-1] ? {CNT_W{1'b1}} : acc_q[CNT_W-1:0];
        case (state)
            ST_CAPTURE: state_nxt = ST_COUNT;
            ST_COUNT:   state_nxt = (idx_q == {CNT_W{1'b1}}) ? ST_UPDATE : ST_COUNT;
            ST_UPDATE:  state_nxt = ST_CAPTURE;
            default:    state_nxt = ST_CAPTURE;
        endcase
    end

    // Datapath: shift register, accumulator, bit index and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    shift_q <= d_in;
                    acc_q   <= '0;
                    idx_q   <= '0;
                end
                ST_COUNT: begin
                    acc_q   <= acc_q + ACC_W'(shift_q[0]);
                    shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                    idx_q   <= idx_q + CNT_W'(1);
                end
                ST_UPDATE: begin
                    bit_cnt <= acc_sat_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit1_counter.sv
// Scoreboard bench for bit1_counter: the driver queues expected counts per captured
// word; the monitor pops at each result edge and checks bit_cnt holds in between.
module tb_bit1_counter;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic [2:0] bit_cnt;

    int         checks;
    int         passes;
    int         edge_cnt;
    logic [2:0] held;
    logic [2:0] exp_q[$];

    bit1_counter dut (
        .clk     (clk),
        .rst     (rst),
        .d_in    (d_in),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; every 10th one is a result edge
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: bit_cnt=%0d expected=%0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [2:0] sat_pop(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

    // Monitor: result edges pop the scoreboard, other edges must show the held value
    always @(negedge clk) begin
        if (!rst) begin
            held = 3'd0;
        end else if (edge_cnt != 0 && edge_cnt % 10 == 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL underflow: bit_cnt=%0d with no expected value at t=%0t", bit_cnt, $time);
            end else begin
                held = exp_q.pop_front();
                check("result", int'(bit_cnt), int'(held));
            end
        end else begin
            check("hold", int'(bit_cnt), int'(held));
        end
    end

    // Present a word just before a capture edge; optionally disturb d_in mid-count
    task automatic apply(input logic [7:0] v, input logic [2:0] e, input bit glitch);
        @(negedge clk);
        while (edge_cnt % 10 != 0) @(negedge clk);
        d_in = v;
        exp_q.push_back(e);
        @(posedge clk);
        if (glitch) begin
            repeat (3) @(negedge clk);
            d_in = 8'h00;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passes = 0;
        held   = 3'd0;
        rst    = 1'b0;
        d_in   = 8'h00;

        // Power-on reset for two clocks
        @(posedge clk);
        #1 check("reset_hold", int'(bit_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic counts, first result 10 edges after release
        apply(8'hB9, 3'd5, 1'b0);
        apply(8'h01, 3'd1, 1'b0);
        apply(8'h23, 3'd3, 1'b0);
        apply(8'h46, 3'd3, 1'b0);
        apply(8'h00, 3'd0, 1'b0);

        // Saturation and extremes
        apply(8'hFF, 3'd7, 1'b0);
        apply(8'h7F, 3'd7, 1'b0);
        apply(8'h80, 3'd1, 1'b0);

        // d_in changes during COUNT must not disturb the result in progress
        apply(8'hB9, 3'd5, 1'b1);
        apply(8'h00, 3'd0, 1'b0);

        // Reset mid-COUNT while bit_cnt shows 5
        apply(8'hB9, 3'd5, 1'b0);
        @(negedge clk);
        while (edge_cnt % 10 != 0) @(negedge clk);
        d_in = 8'hF0;
        repeat (4) @(negedge clk);
        check("pre_reset", int'(bit_cnt), 5);
        #2 rst = 1'b0;
        #1 check("async_reset", int'(bit_cnt), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 check("reset_mid", int'(bit_cnt), 0);
        rst = 1'b1;
        apply(8'h0F, 3'd4, 1'b0);

        // Exhaustive sweep aligned to capture
        for (int v = 0; v < 256; v++) begin
            apply(8'(v), sat_pop(8'(v)), 1'b0);
        end

        // Let the last result drain
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        #1 check("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bit1_counter.md
BIT1_COUNTER -- requirements
Module: Bit1_Counter

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits and the count width at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 d_in  input  8  data word whose 1-bits are counted.
REQ-005 bit_cnt  output  3  registered count of 1-bits in the most recently sampled d_in.

Function
REQ-006 The block SHALL count 1-bits serially with a control FSM of three states: CAPTURE, COUNT, UPDATE.
REQ-007 In CAPTURE, on the next rising edge the block SHALL load d_in into an 8-bit shift register, clear a 4-bit accumulator and a 3-bit bit index, and enter COUNT.
REQ-008 In COUNT, on each rising edge the block SHALL add shift-register bit 0 to the accumulator, shift the register right by one with zero fill, and increment the bit index.
REQ-009 COUNT SHALL last exactly 8 clocks; after the edge that processes index 7, the FSM SHALL enter UPDATE.
REQ-010 In UPDATE, on the next rising edge bit_cnt SHALL be loaded with the accumulator value, saturated to 7: accumulator 8 gives bit_cnt = 3'd7, and 0..7 pass through unchanged. The FSM SHALL then return to CAPTURE.
REQ-011 The cycle SHALL repeat continuously with no start or handshake input, giving a fixed period of 10 clocks per result.
REQ-012 bit_cnt SHALL change only on the UPDATE edge and SHALL hold its value at all other times.
REQ-013 Latency SHALL be 10 rising edges from the CAPTURE sampling edge to the UPDATE edge that presents the result.
REQ-014 d_in SHALL be sampled only at the CAPTURE edge; changes to d_in during COUNT or UPDATE SHALL NOT affect the result in progress.
REQ-015 A d_in value held stable for 10 or more consecutive clocks SHALL appear on bit_cnt within 20 clocks of its first application.
REQ-016 The accumulator SHALL be 4 bits wide internally, so a count of 8 never wraps before saturation.
REQ-017 The FSM SHALL return to CAPTURE from any illegal state encoding on the next edge.

Reset
REQ-018 While rst = 0, the block SHALL immediately, without waiting for a clock edge, force bit_cnt = 0, shift register = 0, accumulator = 0, bit index = 0 and FSM = CAPTURE.
REQ-019 A reset asserted mid-COUNT SHALL discard the partial count; bit_cnt SHALL read 0 and stay 0 until the first UPDATE after release.
REQ-020 After rst rises, the first rising edge SHALL perform CAPTURE, and the first result SHALL appear on the 10th edge after release.

Verification
REQ-021 Hold rst = 0 for 2 clocks, then release; apply d_in = 8'hB9 for 12 clocks -> bit_cnt = 5 at the next UPDATE, and 0 before it.
REQ-022 Apply the sequence 8'h01, 8'h23, 8'h46, 8'h00, each held 12 clocks -> bit_cnt = 1, 3, 3, 0 respectively, each value held for at least one full 10-clock period.
REQ-023 Apply d_in = 8'hFF -> bit_cnt = 7 (saturated); then apply 8'h7F -> bit_cnt = 7; then apply 8'h80 -> bit_cnt = 1.
REQ-024 Capture 8'hB9, then change d_in to 8'h00 during COUNT -> the next UPDATE gives 5, and the following UPDATE gives 0.
REQ-025 Drive rst = 0 mid-COUNT while bit_cnt = 5 -> bit_cnt = 0 at once without a clock edge; after release, the result appears exactly 10 edges later.
REQ-026 Sweep d_in = 0..255, each value held 10 clocks and aligned to CAPTURE -> every bit_cnt equals min(popcount(d_in), 7).
